// File: rtl/dp_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : dp_ctrl_seq
// Brief    : Micro-instruction sequencer that replays a loaded program of
//            control words, each with a repeat count, onto a datapath.
// Revision : 1.0 - initial release
// ============================================================================
module dp_ctrl_seq #(
    parameter int num_col      = 6,
    parameter int dwidth_RFadd = 4,
    parameter int IMEM_DEPTH   = 16,
    parameter int CNT_W        = 8,
    localparam int CW_W = (num_col - 1) * (4 + 2 + 2 * dwidth_RFadd) + num_col,
    localparam int AW   = $clog2(IMEM_DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 prog_valid,
    input  logic [CW_W+CNT_W-1:0]                prog_word,
    output logic                                 prog_ready,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 stream_valid,
    output logic [(num_col-1)*4-1:0]             sel_mux4,
    output logic [(num_col-1)*2-1:0]             op,
    output logic [num_col-1:0]                   wen_RF,
    output logic [dwidth_RFadd*(num_col-1)-1:0]  rd_addr_RF,
    output logic [dwidth_RFadd*(num_col-1)-1:0]  wr_addr_RF,
    output logic                                 issue_valid,
    output logic                                 busy,
    output logic                                 done,
    output logic [LW-1:0]                        prog_len
);

    localparam int c_SEL_W  = (num_col - 1) * 4;
    localparam int c_OP_W   = (num_col - 1) * 2;
    localparam int c_WEN_W  = num_col;
    localparam int c_AD_W   = dwidth_RFadd * (num_col - 1);
    localparam int c_OP_LO  = c_SEL_W;
    localparam int c_WEN_LO = c_OP_LO + c_OP_W;
    localparam int c_RD_LO  = c_WEN_LO + c_WEN_W;
    localparam int c_WR_LO  = c_RD_LO + c_AD_W;
    localparam int c_PW     = CW_W + CNT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_pc;
    logic [CNT_W-1:0]   r_rep;
    logic [LW-1:0]      r_len;
    logic [CW_W-1:0]    r_cw;
    logic               r_busy;
    logic               r_done;
    logic [c_PW-1:0]    r_imem [IMEM_DEPTH];

    logic               w_ready;
    logic               w_load;
    logic               w_start;
    logic               w_last;
    logic               w_beat;
    logic [AW-1:0]      w_pc_nxt;
    logic [c_PW-1:0]    w_word0;
    logic [c_PW-1:0]    w_next;

    assign w_ready  = (r_state == S_IDLE) && (r_len < LW'(IMEM_DEPTH));
    assign w_load   = prog_valid && w_ready;
    assign w_pc_nxt = r_pc + AW'(1);
    assign w_next   = r_imem[w_pc_nxt];
    assign w_last   = ({1'b0, r_pc} == (r_len - LW'(1)));
    assign w_beat   = (r_state == S_RUN) && stream_valid;

    // A word loaded in the start cycle into an empty program becomes word 0
    // before the memory write lands, so forward it.
    assign w_word0  = (r_len == '0) ? prog_word : r_imem[0];
    assign w_start  = start && !abort && ((r_len != '0) || w_load);

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_imem[r_len[AW-1:0]] <= prog_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_rep   <= '0;
            r_len   <= '0;
            r_cw    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (abort) begin
                        r_len <= '0;
                    end else begin
                        if (w_load) begin
                            r_len <= r_len + LW'(1);
                        end
                        if (w_start) begin
                            r_state <= S_RUN;
                            r_pc    <= '0;
                            r_rep   <= w_word0[c_PW-1:CW_W];
                            r_cw    <= w_word0[CW_W-1:0];
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (stream_valid) begin
                        if (r_rep != '0) begin
                            r_rep <= r_rep - CNT_W'(1);
                        end else if (!w_last) begin
                            r_pc  <= w_pc_nxt;
                            r_rep <= w_next[c_PW-1:CW_W];
                            r_cw  <= w_next[CW_W-1:0];
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_cw    <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_cw    <= '0;
                end
            endcase
        end
    end

    // Stalls hold the word but must never write the register file.
    assign wen_RF      = w_beat ? r_cw[c_WEN_LO +: c_WEN_W] : '0;
    assign issue_valid = w_beat;

    assign sel_mux4    = r_cw[0 +: c_SEL_W];
    assign op          = r_cw[c_OP_LO +: c_OP_W];
    assign rd_addr_RF  = r_cw[c_RD_LO +: c_AD_W];
    assign wr_addr_RF  = r_cw[c_WR_LO +: c_AD_W];
    assign prog_ready  = w_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign prog_len    = r_len;

endmodule
`default_nettype wire

// File: tb/tb_dp_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_ctrl_seq
// Brief    : Directed self-checking bench for the dp_ctrl_seq sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_ctrl_seq;

    localparam int c_CW_W = 76;
    localparam int c_PW   = 84;

    logic               clk = 1'b0;
    logic               rst;
    logic               prog_valid;
    logic [c_PW-1:0]    prog_word;
    logic               prog_ready;
    logic               start;
    logic               abort;
    logic               stream_valid;
    logic [19:0]        sel_mux4;
    logic [9:0]         op;
    logic [5:0]         wen_RF;
    logic [19:0]        rd_addr_RF;
    logic [19:0]        wr_addr_RF;
    logic               issue_valid;
    logic               busy;
    logic               done;
    logic [4:0]         prog_len;

    int n_chk  = 0;
    int n_fail = 0;
    int n_iss;

    dp_ctrl_seq #(
        .num_col      (6),
        .dwidth_RFadd (4),
        .IMEM_DEPTH   (16),
        .CNT_W        (8)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .prog_valid   (prog_valid),
        .prog_word    (prog_word),
        .prog_ready   (prog_ready),
        .start        (start),
        .abort        (abort),
        .stream_valid (stream_valid),
        .sel_mux4     (sel_mux4),
        .op           (op),
        .wen_RF       (wen_RF),
        .rd_addr_RF   (rd_addr_RF),
        .wr_addr_RF   (wr_addr_RF),
        .issue_valid  (issue_valid),
        .busy         (busy),
        .done         (done),
        .prog_len     (prog_len)
    );

    always #5 clk = ~clk;

    // Distinct, recognisable field patterns per word index.
    function automatic logic [c_PW-1:0] mkw(input int idx, input int cnt);
        logic [19:0] s;
        logic [9:0]  o;
        logic [5:0]  w;
        logic [19:0] r;
        logic [19:0] a;
        s = {5{4'(idx + 1)}};
        o = {5{2'(idx + 1)}};
        w = 6'(idx * 7 + 5);
        r = {5{4'(idx + 3)}};
        a = {5{4'(idx + 9)}};
        return {8'(cnt), a, r, w, o, s};
    endfunction

    task automatic chk_eq(input string tag, input logic [c_PW-1:0] got, input logic [c_PW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_fields(input string tag, input int idx, input logic sv);
        logic [c_PW-1:0] w;
        w = mkw(idx, 0);
        chk_eq({tag, ".sel"}, c_PW'(sel_mux4),   c_PW'(w[19:0]));
        chk_eq({tag, ".op"},  c_PW'(op),         c_PW'(w[29:20]));
        chk_eq({tag, ".wen"}, c_PW'(wen_RF),     sv ? c_PW'(w[35:30]) : '0);
        chk_eq({tag, ".rd"},  c_PW'(rd_addr_RF), c_PW'(w[55:36]));
        chk_eq({tag, ".wr"},  c_PW'(wr_addr_RF), c_PW'(w[75:56]));
    endtask

    task automatic chk_zero(input string tag);
        chk_eq({tag, ".sel0"}, c_PW'(sel_mux4),   '0);
        chk_eq({tag, ".op0"},  c_PW'(op),         '0);
        chk_eq({tag, ".wen0"}, c_PW'(wen_RF),     '0);
        chk_eq({tag, ".rd0"},  c_PW'(rd_addr_RF), '0);
        chk_eq({tag, ".wr0"},  c_PW'(wr_addr_RF), '0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [c_PW-1:0] w);
        prog_valid = 1'b1;
        prog_word  = w;
        cyc();
        prog_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seq_a[6];
        int seq_c[5];
        int idx;
        seq_a = '{0, 1, 1, 1, 2, 2};
        seq_c = '{3, 3, 4, 5, 6};
        rst = 1'b1; prog_valid = 1'b0; prog_word = '0;
        start = 1'b0; abort = 1'b0; stream_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk_eq("rst.busy",  c_PW'(busy),        '0);
        chk_eq("rst.done",  c_PW'(done),        '0);
        chk_eq("rst.issue", c_PW'(issue_valid), '0);
        chk_eq("rst.len",   c_PW'(prog_len),    '0);
        chk_eq("rst.ready", c_PW'(prog_ready),  c_PW'(1));
        chk_zero("rst");

        // Counts 0,2,1 with continuous stream
        load_word(mkw(0, 0));
        load_word(mkw(1, 2));
        load_word(mkw(2, 1));
        chk_eq("A.len", c_PW'(prog_len), c_PW'(3));
        start = 1'b1; stream_valid = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk_fields("A", seq_a[c], 1'b1);
            chk_eq("A.busy",  c_PW'(busy),        c_PW'(1));
            chk_eq("A.issue", c_PW'(issue_valid), c_PW'(1));
            chk_eq("A.done",  c_PW'(done),        '0);
            cyc();
        end
        chk_eq("A.done7",  c_PW'(done),        c_PW'(1));
        chk_eq("A.busy7",  c_PW'(busy),        '0);
        chk_eq("A.issue7", c_PW'(issue_valid), '0);
        cyc();
        chk_eq("A.done8", c_PW'(done),       '0);
        chk_eq("A.len8",  c_PW'(prog_len),   c_PW'(3));
        chk_eq("A.rdy8",  c_PW'(prog_ready), c_PW'(1));
        chk_zero("A.idle");

        // Same program, alternating stall cycles
        start = 1'b1; stream_valid = 1'b0;
        cyc();
        start = 1'b0;
        n_iss = 0;
        for (int c = 1; c <= 11; c++) begin
            stream_valid = logic'(c % 2);
            #1;
            idx = (c % 2 == 1) ? seq_a[(c - 1) / 2] : seq_a[c / 2];
            chk_fields("B", idx, stream_valid);
            chk_eq("B.issue", c_PW'(issue_valid), c_PW'(stream_valid));
            chk_eq("B.busy",  c_PW'(busy),        c_PW'(1));
            if (issue_valid) n_iss++;
            cyc();
        end
        chk_eq("B.beats", c_PW'(n_iss), c_PW'(6));
        chk_eq("B.done",  c_PW'(done),  c_PW'(1));
        stream_valid = 1'b0;
        cyc();
        chk_eq("B.done_end", c_PW'(done), '0);

        // Abort in IDLE discards; abort mid-run ends after two beats
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk_eq("C.clr", c_PW'(prog_len), '0);
        load_word(mkw(3, 1));
        load_word(mkw(4, 0));
        load_word(mkw(5, 0));
        load_word(mkw(6, 0));
        chk_eq("C.len", c_PW'(prog_len), c_PW'(4));
        start = 1'b1; stream_valid = 1'b1;
        cyc();
        start = 1'b0;
        chk_fields("C1", 3, 1'b1);
        chk_eq("C1.issue", c_PW'(issue_valid), c_PW'(1));
        cyc();
        abort = 1'b1;
        #1;
        chk_fields("C2", 3, 1'b1);
        chk_eq("C2.issue", c_PW'(issue_valid), c_PW'(1));
        cyc();
        abort = 1'b0;
        chk_eq("C3.done",  c_PW'(done),        c_PW'(1));
        chk_eq("C3.issue", c_PW'(issue_valid), '0);
        chk_eq("C3.wen",   c_PW'(wen_RF),      '0);
        chk_eq("C3.busy",  c_PW'(busy),        '0);
        cyc();
        chk_eq("C4.done", c_PW'(done),     '0);
        chk_eq("C4.len",  c_PW'(prog_len), c_PW'(4));
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk_fields("C.rerun", seq_c[c], 1'b1);
            cyc();
        end
        chk_eq("C.rerun_done", c_PW'(done), c_PW'(1));
        cyc();

        // Reset between edges during RUN
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_eq("D.busy", c_PW'(busy), c_PW'(1));
        cyc();
        #3 rst = 1'b1;
        #1;
        chk_eq("D.busy0",  c_PW'(busy),        '0);
        chk_eq("D.issue0", c_PW'(issue_valid), '0);
        chk_eq("D.done0",  c_PW'(done),        '0);
        chk_eq("D.len0",   c_PW'(prog_len),    '0);
        chk_zero("D");
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk_eq("D.ready", c_PW'(prog_ready), c_PW'(1));
        start = 1'b1;
        cyc();
        cyc();
        chk_eq("D.nostart_busy", c_PW'(busy), '0);
        chk_eq("D.nostart_done", c_PW'(done), '0);
        start = 1'b0;
        cyc();
        chk_eq("D.nostart_done2", c_PW'(done), '0);

        // Fill to capacity, extra word ignored, then run all 16
        for (int i = 0; i < 16; i++) begin
            load_word(mkw(i, 0));
        end
        chk_eq("E.ready", c_PW'(prog_ready), '0);
        chk_eq("E.len",   c_PW'(prog_len),   c_PW'(16));
        load_word(mkw(20, 0));
        chk_eq("E.len17", c_PW'(prog_len), c_PW'(16));
        start = 1'b1; stream_valid = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_fields("E.run", k, 1'b1);
            cyc();
        end
        chk_eq("E.done", c_PW'(done), c_PW'(1));
        cyc();

        // Load and start in the same cycle into an empty program
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk_eq("F.clr", c_PW'(prog_len), '0);
        prog_valid = 1'b1; prog_word = mkw(7, 1); start = 1'b1;
        cyc();
        prog_valid = 1'b0; start = 1'b0;
        chk_eq("F.busy", c_PW'(busy),     c_PW'(1));
        chk_eq("F.len",  c_PW'(prog_len), c_PW'(1));
        chk_fields("F1", 7, 1'b1);
        cyc();
        chk_fields("F2", 7, 1'b1);
        cyc();
        chk_eq("F.done", c_PW'(done), c_PW'(1));
        stream_valid = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
